// File: rtl/rs_pkg.sv
// Shared types and defaults for the reservation-station block: function codes,
// datapath widths and the station entry record.
package rs_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;
  localparam int ROB_AW = 3;

  localparam logic [3:0] FUNC_ADD = 4'b0000;
  localparam logic [3:0] FUNC_SUB = 4'b0001;
  localparam logic [3:0] FUNC_MUL = 4'b0010;
  localparam logic [3:0] FUNC_DIV = 4'b0011;

  typedef struct packed {
    logic              busy;
    logic [3:0]        func;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [ROB_AW-1:0] qj;
    logic [ROB_AW-1:0] qk;
    logic              rj;
    logic              rk;
    logic [ROB_AW-1:0] rob;
    logic [REG_AW-1:0] rd;
  } rs_entry_t;

  function automatic logic func_is_add(input logic [3:0] f);
    return (f == FUNC_ADD) || (f == FUNC_SUB);
  endfunction

  function automatic logic func_is_mul(input logic [3:0] f);
    return (f == FUNC_MUL) || (f == FUNC_DIV);
  endfunction

endpackage

// File: rtl/rs_bank.sv
// One reservation station of N entries: append into the lowest free slot, CDB snoop, one dispatch per cycle.
// Dispatch order is lowest-index ready; with OLDEST_FIRST_EN defined it is oldest ready (ties to lower index).
module rs_bank
  import rs_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1,
  localparam int CW = $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              app_we_i,
  input  rs_entry_t         app_ent_i,
  input  logic              cdb_valid_i,
  input  logic [ROB_AW-1:0] cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_data_i,
  output logic              free_o,
  output logic              disp_valid_o,
  input  logic              disp_ready_i,
  output logic [3:0]        disp_func_o,
  output logic [DATA_W-1:0] disp_vj_o,
  output logic [DATA_W-1:0] disp_vk_o,
  output logic [ROB_AW-1:0] disp_rob_o,
  output logic [REG_AW-1:0] disp_rd_o,
  output logic [CW-1:0]     count_o
);

  rs_entry_t [N-1:0] ent_q, ent_d;
  logic [N-1:0]      rdy;
  logic [IW-1:0]     free_idx, sel_idx;
  logic              sel_vld;

  always_comb begin
    free_o   = 1'b0;
    free_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!ent_q[i].busy) begin
        free_o   = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      rdy[i] = ent_q[i].busy & ent_q[i].rj & ent_q[i].rk;
    end
  end

`ifdef OLDEST_FIRST_EN
  localparam int AW = IW + 1;
  logic [N-1:0][AW-1:0] age_q, age_d;
  logic [AW-1:0]        best_age;

  // Every append ages the entries already resident; a larger age means older.
  always_comb begin
    age_d = age_q;
    if (app_we_i) begin
      for (int i = 0; i < N; i++) begin
        if (IW'(i) == free_idx) begin
          age_d[i] = '0;
        end else if (ent_q[i].busy && (age_q[i] != '1)) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    best_age = '0;
    for (int i = 0; i < N; i++) begin
      if (rdy[i] && (!sel_vld || (age_q[i] > best_age))) begin
        sel_vld  = 1'b1;
        sel_idx  = IW'(i);
        best_age = age_q[i];
      end
    end
  end
`else
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        sel_vld = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end
`endif

  assign disp_valid_o = sel_vld;
  assign disp_func_o  = ent_q[sel_idx].func;
  assign disp_vj_o    = ent_q[sel_idx].vj;
  assign disp_vk_o    = ent_q[sel_idx].vk;
  assign disp_rob_o   = ent_q[sel_idx].rob;
  assign disp_rd_o    = ent_q[sel_idx].rd;

  // The append slot comes from registered busy bits, so it never collides with the dispatched entry.
  always_comb begin
    ent_d = ent_q;
    if (cdb_valid_i) begin
      for (int i = 0; i < N; i++) begin
        if (ent_q[i].busy && !ent_q[i].rj && (ent_q[i].qj == cdb_tag_i)) begin
          ent_d[i].vj = cdb_data_i;
          ent_d[i].rj = 1'b1;
        end
        if (ent_q[i].busy && !ent_q[i].rk && (ent_q[i].qk == cdb_tag_i)) begin
          ent_d[i].vk = cdb_data_i;
          ent_d[i].rk = 1'b1;
        end
      end
    end
    if (sel_vld && disp_ready_i) begin
      ent_d[sel_idx].busy = 1'b0;
    end
    if (app_we_i) begin
      ent_d[free_idx] = app_ent_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  always_comb begin
    count_o = '0;
    for (int i = 0; i < N; i++) begin
      count_o = count_o + CW'(ent_q[i].busy);
    end
  end

endmodule

// File: rtl/rstation_append.sv
// Reservation-station front end: decodes the issued function into the ADD or MUL station and resolves operands.
// Dispatch policy is selected inside rs_bank by OLDEST_FIRST_EN; ports are the same in both builds.
module rstation_append
  import rs_pkg::*;
#(
  parameter int ADD_N = 2,
  parameter int MUL_N = 2
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              app_valid,
  input  logic [3:0]        app_func,
  input  logic [REG_AW-1:0] app_rs1,
  input  logic [REG_AW-1:0] app_rs2,
  input  logic [REG_AW-1:0] app_rd,
  input  logic [ROB_AW-1:0] app_rob_ind,
  input  logic [DATA_W-1:0] src1_val,
  input  logic              src1_busy,
  input  logic [ROB_AW-1:0] src1_tag,
  input  logic [DATA_W-1:0] src2_val,
  input  logic              src2_busy,
  input  logic [ROB_AW-1:0] src2_tag,
  input  logic              cdb_valid,
  input  logic [ROB_AW-1:0] cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              app_ready,
  output logic              add_disp_valid,
  input  logic              add_disp_ready,
  output logic [3:0]        add_disp_func,
  output logic [DATA_W-1:0] add_disp_vj,
  output logic [DATA_W-1:0] add_disp_vk,
  output logic [ROB_AW-1:0] add_disp_rob,
  output logic [REG_AW-1:0] add_disp_rd,
  output logic              mul_disp_valid,
  input  logic              mul_disp_ready,
  output logic [3:0]        mul_disp_func,
  output logic [DATA_W-1:0] mul_disp_vj,
  output logic [DATA_W-1:0] mul_disp_vk,
  output logic [ROB_AW-1:0] mul_disp_rob,
  output logic [REG_AW-1:0] mul_disp_rd,
  output logic [1:0]        add_count,
  output logic [1:0]        mul_count
);

  logic      is_add, is_mul, add_free, mul_free, add_we, mul_we;
  rs_entry_t new_ent;
  logic      unused_dbg;

  assign unused_dbg = ^{app_rs1, app_rs2};

  assign is_add    = func_is_add(app_func);
  assign is_mul    = func_is_mul(app_func);
  assign app_ready = (is_add & add_free) | (is_mul & mul_free);
  assign add_we    = app_valid & is_add & add_free;
  assign mul_we    = app_valid & is_mul & mul_free;

  // A source still in flight can be satisfied by the CDB broadcast of this very cycle.
  always_comb begin
    new_ent      = '0;
    new_ent.busy = 1'b1;
    new_ent.func = app_func;
    new_ent.rob  = app_rob_ind;
    new_ent.rd   = app_rd;
    if (!src1_busy) begin
      new_ent.vj = src1_val;
      new_ent.rj = 1'b1;
    end else if (cdb_valid && (cdb_tag == src1_tag)) begin
      new_ent.vj = cdb_data;
      new_ent.rj = 1'b1;
    end else begin
      new_ent.qj = src1_tag;
    end
    if (!src2_busy) begin
      new_ent.vk = src2_val;
      new_ent.rk = 1'b1;
    end else if (cdb_valid && (cdb_tag == src2_tag)) begin
      new_ent.vk = cdb_data;
      new_ent.rk = 1'b1;
    end else begin
      new_ent.qk = src2_tag;
    end
  end

  rs_bank #(.N(ADD_N)) u_add_bank (
    .clk          (clk1),
    .rst_n        (rst_n),
    .app_we_i     (add_we),
    .app_ent_i    (new_ent),
    .cdb_valid_i  (cdb_valid),
    .cdb_tag_i    (cdb_tag),
    .cdb_data_i   (cdb_data),
    .free_o       (add_free),
    .disp_valid_o (add_disp_valid),
    .disp_ready_i (add_disp_ready),
    .disp_func_o  (add_disp_func),
    .disp_vj_o    (add_disp_vj),
    .disp_vk_o    (add_disp_vk),
    .disp_rob_o   (add_disp_rob),
    .disp_rd_o    (add_disp_rd),
    .count_o      (add_count)
  );

  rs_bank #(.N(MUL_N)) u_mul_bank (
    .clk          (clk1),
    .rst_n        (rst_n),
    .app_we_i     (mul_we),
    .app_ent_i    (new_ent),
    .cdb_valid_i  (cdb_valid),
    .cdb_tag_i    (cdb_tag),
    .cdb_data_i   (cdb_data),
    .free_o       (mul_free),
    .disp_valid_o (mul_disp_valid),
    .disp_ready_i (mul_disp_ready),
    .disp_func_o  (mul_disp_func),
    .disp_vj_o    (mul_disp_vj),
    .disp_vk_o    (mul_disp_vk),
    .disp_rob_o   (mul_disp_rob),
    .disp_rd_o    (mul_disp_rd),
    .count_o      (mul_count)
  );

endmodule

// File: tb/tb_rstation_append.sv
// Directed bench for rstation_append: append, operand capture, CDB wake-up, full/illegal refusal, async reset.
module tb_rstation_append;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        app_valid;
  logic [3:0]  app_func;
  logic [3:0]  app_rs1, app_rs2, app_rd;
  logic [2:0]  app_rob_ind;
  logic [15:0] src1_val, src2_val;
  logic        src1_busy, src2_busy;
  logic [2:0]  src1_tag, src2_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        app_ready;
  logic        add_disp_valid, add_disp_ready, mul_disp_valid, mul_disp_ready;
  logic [3:0]  add_disp_func, mul_disp_func;
  logic [15:0] add_disp_vj, add_disp_vk, mul_disp_vj, mul_disp_vk;
  logic [2:0]  add_disp_rob, mul_disp_rob;
  logic [3:0]  add_disp_rd, mul_disp_rd;
  logic [1:0]  add_count, mul_count;

  int checks = 0;
  int errors = 0;

  always #5 clk1 = ~clk1;

  rstation_append dut (
    .clk1(clk1), .rst_n(rst_n), .app_valid(app_valid), .app_func(app_func),
    .app_rs1(app_rs1), .app_rs2(app_rs2), .app_rd(app_rd), .app_rob_ind(app_rob_ind),
    .src1_val(src1_val), .src1_busy(src1_busy), .src1_tag(src1_tag),
    .src2_val(src2_val), .src2_busy(src2_busy), .src2_tag(src2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .app_ready(app_ready),
    .add_disp_valid(add_disp_valid), .add_disp_ready(add_disp_ready),
    .add_disp_func(add_disp_func), .add_disp_vj(add_disp_vj), .add_disp_vk(add_disp_vk),
    .add_disp_rob(add_disp_rob), .add_disp_rd(add_disp_rd),
    .mul_disp_valid(mul_disp_valid), .mul_disp_ready(mul_disp_ready),
    .mul_disp_func(mul_disp_func), .mul_disp_vj(mul_disp_vj), .mul_disp_vk(mul_disp_vk),
    .mul_disp_rob(mul_disp_rob), .mul_disp_rd(mul_disp_rd),
    .add_count(add_count), .mul_count(mul_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic app(input logic vld, input logic [3:0] func, input logic [2:0] rob,
                     input logic [15:0] v1, input logic b1, input logic [2:0] t1,
                     input logic [15:0] v2, input logic b2, input logic [2:0] t2);
    app_valid   = vld;
    app_func    = func;
    app_rob_ind = rob;
    app_rd      = 4'(rob) + 4'd1;
    src1_val = v1; src1_busy = b1; src1_tag = t1;
    src2_val = v2; src2_busy = b2; src2_tag = t2;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    app_rs1 = 4'd1; app_rs2 = 4'd2;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    add_disp_ready = 1'b0; mul_disp_ready = 1'b0;
    app(1'b0, 4'd0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0);
    #12;
    check("rst_add_count", 32'(add_count), 32'd0);
    check("rst_mul_count", 32'(mul_count), 32'd0);
    check("rst_add_vld", 32'(add_disp_valid), 32'd0);
    check("rst_mul_vld", 32'(mul_disp_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: add with both operands available
    app(1'b1, 4'b0000, 3'd0, 16'd5, 1'b0, 3'd0, 16'd7, 1'b0, 3'd0);
    check("t1_app_ready", 32'(app_ready), 32'd1);
    tick();
    app(1'b0, 4'd0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0);
    check("t1_add_count", 32'(add_count), 32'd1);
    check("t1_add_vld", 32'(add_disp_valid), 32'd1);
    check("t1_vj", 32'(add_disp_vj), 32'd5);
    check("t1_vk", 32'(add_disp_vk), 32'd7);
    check("t1_rob", 32'(add_disp_rob), 32'd0);
    check("t1_rd", 32'(add_disp_rd), 32'd1);
    add_disp_ready = 1'b1;
    tick();
    add_disp_ready = 1'b0;
    check("t1_drained", 32'(add_count), 32'd0);
    check("t1_vld_off", 32'(add_disp_valid), 32'd0);

    // 2: mul waiting on tag 3, woken by CDB
    app(1'b1, 4'b0010, 3'd1, 16'd0, 1'b1, 3'd3, 16'd4, 1'b0, 3'd0);
    tick();
    app(1'b0, 4'd0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0);
    check("t2_mul_count", 32'(mul_count), 32'd1);
    check("t2_wait", 32'(mul_disp_valid), 32'd0);
    cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 16'h00AA;
    tick();
    cdb_valid = 1'b0;
    check("t2_mul_vld", 32'(mul_disp_valid), 32'd1);
    check("t2_vj", 32'(mul_disp_vj), 32'h00AA);
    check("t2_vk", 32'(mul_disp_vk), 32'd4);
    check("t2_func", 32'(mul_disp_func), 32'd2);
    mul_disp_ready = 1'b1;
    tick();
    mul_disp_ready = 1'b0;
    check("t2_drained", 32'(mul_count), 32'd0);

    // 3: sub whose src2 arrives on the CDB in the append cycle
    app(1'b1, 4'b0001, 3'd2, 16'd1, 1'b0, 3'd0, 16'd0, 1'b1, 3'd2);
    cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 16'd9;
    tick();
    cdb_valid = 1'b0;
    app(1'b0, 4'd0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0);
    check("t3_add_vld", 32'(add_disp_valid), 32'd1);
    check("t3_vk", 32'(add_disp_vk), 32'd9);
    check("t3_vj", 32'(add_disp_vj), 32'd1);
    check("t3_func", 32'(add_disp_func), 32'd1);
    add_disp_ready = 1'b1;
    tick();
    add_disp_ready = 1'b0;
    check("t3_drained", 32'(add_count), 32'd0);

    // 4: fill ADD station while FU stalls
    app(1'b1, 4'b0000, 3'd3, 16'd10, 1'b0, 3'd0, 16'd11, 1'b0, 3'd0);
    tick();
    app(1'b1, 4'b0000, 3'd4, 16'd12, 1'b0, 3'd0, 16'd13, 1'b0, 3'd0);
    tick();
    app(1'b1, 4'b0000, 3'd5, 16'd14, 1'b0, 3'd0, 16'd15, 1'b0, 3'd0);
    check("t4_full_count", 32'(add_count), 32'd2);
    check("t4_full_ready", 32'(app_ready), 32'd0);
    tick();
    check("t4_count_held", 32'(add_count), 32'd2);
    check("t4_disp_rob", 32'(add_disp_rob), 32'd3);
    app(1'b1, 4'b0011, 3'd5, 16'd3, 1'b0, 3'd0, 16'd5, 1'b0, 3'd0);
    check("t4_mul_ready", 32'(app_ready), 32'd1);
    tick();
    check("t4_mul_count", 32'(mul_count), 32'd1);
    check("t4_mul_vld", 32'(mul_disp_valid), 32'd1);

    // 5: dispatch and append on the same edge of a full station
    app(1'b1, 4'b0000, 3'd6, 16'd20, 1'b0, 3'd0, 16'd21, 1'b0, 3'd0);
    add_disp_ready = 1'b1;
    #1;
    check("t5_refused", 32'(app_ready), 32'd0);
    tick();
    add_disp_ready = 1'b0;
    #1;
    check("t5_count_1", 32'(add_count), 32'd1);
    check("t5_next_rob", 32'(add_disp_rob), 32'd4);
    check("t5_accept", 32'(app_ready), 32'd1);
    tick();
    app(1'b0, 4'd0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0);
    check("t5_count_2", 32'(add_count), 32'd2);
`ifdef OLDEST_FIRST_EN
    check("t5_order", 32'(add_disp_rob), 32'd4);
`else
    check("t5_order", 32'(add_disp_rob), 32'd6);
`endif

    // 6: illegal function, then reset mid-run
    app(1'b1, 4'b0101, 3'd7, 16'd1, 1'b0, 3'd0, 16'd1, 1'b0, 3'd0);
    check("t6_illegal_rdy", 32'(app_ready), 32'd0);
    tick();
    check("t6_add_count", 32'(add_count), 32'd2);
    check("t6_mul_count", 32'(mul_count), 32'd1);
    app(1'b0, 4'd0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_add", 32'(add_count), 32'd0);
    check("t6_rst_mul", 32'(mul_count), 32'd0);
    check("t6_rst_addv", 32'(add_disp_valid), 32'd0);
    check("t6_rst_mulv", 32'(mul_disp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
